// File: rtl/bram_loader_layer00.sv
// bram_loader_layer00: round-robin stream loader for the 16-bank layer-00 input feature-map DPRAM array.
// Optional macro LOADER_CHECKSUM_EN adds oChecksum, the mod-2^32 sum of all 32-bit lanes written in a load.
module bram_loader_layer00 #(
  parameter int DW    = 128,
  parameter int AW    = 9,
  parameter int NBANK = 16,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             iStart,
  input  logic [13:0]      iNumWords,
  input  logic             iValid,
  input  logic [DW-1:0]    iData,
  output logic             oReady,
  output logic [NBANK-1:0] o_ena,
  output logic [NBANK-1:0] o_wea,
  output logic [AW-1:0]    o_addra,
  output logic [DW-1:0]    o_dia,
  output logic             oBusy,
  output logic             oDone
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      oChecksum
`endif
);
  localparam int BW = $clog2(NBANK);
  localparam logic [13:0] CAP = 14'(NBANK * DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} stateT;
  stateT state, stateNext;
  logic [13:0] numWords, wordCnt, startCount;
  logic [BW-1:0] bankIdx;
  logic [AW-1:0] addrCnt;
  logic [NBANK-1:0] bankSel;
  logic accept, startOk;
  assign bankSel = NBANK'(1) << bankIdx;
  // Next-state and handshake/status decode; N is saturated to array capacity before use.
  always_comb begin
    startCount = iNumWords > CAP ? CAP : iNumWords;
    oReady = state == LOAD;
    oBusy = state == LOAD || state == FLUSH;
    oDone = state == DONE;
    accept = iValid & oReady;
    startOk = state == IDLE && iStart;
    stateNext = state;
    case (state)
      IDLE:    stateNext = iStart ? (startCount == '0 ? DONE : LOAD) : IDLE;
      LOAD:    stateNext = accept && wordCnt == numWords - 14'd1 ? FLUSH : LOAD;
      FLUSH:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= stateNext;
  end
  // Counters and the registered write port; a strobe lives exactly one cycle after its accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      numWords <= '0;
      wordCnt <= '0;
      bankIdx <= '0;
      addrCnt <= '0;
      o_ena <= '0;
      o_wea <= '0;
      o_addra <= '0;
      o_dia <= '0;
    end else begin
      o_ena <= accept ? bankSel : '0;
      o_wea <= accept ? bankSel : '0;
      if (startOk) begin
        numWords <= startCount;
        wordCnt <= '0;
        bankIdx <= '0;
        addrCnt <= '0;
      end else if (accept) begin
        wordCnt <= wordCnt + 14'd1;
        bankIdx <= bankIdx + 1'b1;
        addrCnt <= bankIdx == {BW{1'b1}} ? addrCnt + 1'b1 : addrCnt;
        o_addra <= addrCnt;
        o_dia <= iData;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] laneSum;
  // Sum of the 32-bit lanes of the word on the stream this cycle.
  always_comb begin
    laneSum = '0;
    for (int i = 0; i < DW / 32; i++) laneSum = laneSum + iData[i*32 +: 32];
  end
  // Checksum accumulator: cleared by an accepted start, grows on every accepted word.
  always_ff @(posedge clk) begin
    if (!rstn) oChecksum <= '0;
    else if (startOk) oChecksum <= '0;
    else if (accept) oChecksum <= oChecksum + laneSum;
  end
`endif
endmodule

// File: tb/tb_bram_loader_layer00.sv
// tb_bram_loader_layer00: directed self-checking bench for bram_loader_layer00.
module tb_bram_loader_layer00;
  logic clk, rstn, iStart, iValid;
  logic [13:0] iNumWords;
  logic [127:0] iData;
  logic oReady, oBusy, oDone;
  logic [15:0] o_ena, o_wea;
  logic [8:0] o_addra;
  logic [127:0] o_dia;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] oChecksum;
`endif
  int nChecks = 0, nFail = 0;
  int salt = 0, expK = 0, lastBank = -1, lastAddr = -1;
  int bankCnt [16];
  bit bub = 0, monOn = 0;

  bram_loader_layer00 dut (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iNumWords(iNumWords), .iValid(iValid), .iData(iData),
    .oReady(oReady), .o_ena(o_ena), .o_wea(o_wea), .o_addra(o_addra), .o_dia(o_dia),
    .oBusy(oBusy), .oDone(oDone)
`ifdef LOADER_CHECKSUM_EN
    , .oChecksum(oChecksum)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    nChecks++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] dataOf(input int k);
    if (salt == 0) return 128'(k);
    if (salt == 1) return {4{32'd1}};
    return {32'(k * salt), 32'(k + salt), ~32'(k), 32'(k)};
  endfunction

  // Every write strobe must follow word order: bank k%16, address k/16, data of word k.
  always @(negedge clk) begin
    if (monOn && (o_wea != '0 || o_ena != '0)) begin
      check("wr_ena", 128'(o_ena), 128'(16'd1 << (expK % 16)));
      check("wr_wea", 128'(o_wea), 128'(16'd1 << (expK % 16)));
      check("wr_addr", 128'(o_addra), 128'(expK / 16));
      check("wr_data", o_dia, dataOf(expK));
      bankCnt[expK % 16]++;
      lastBank = expK % 16;
      lastAddr = expK / 16;
      expK++;
    end
  end

  task automatic runLoad(input int n, input int abortAt, input int restartAt);
    int want, sent, cyc, since;
    bit acc;
    want = n > 8192 ? 8192 : n;
    sent = 0; cyc = 0; since = -1;
    expK = 0;
    foreach (bankCnt[i]) bankCnt[i] = 0;
    monOn = 1;
    iNumWords = 14'(n); iStart = 1; iValid = 1; iData = dataOf(0);
    @(posedge clk); #1;
    iStart = 0;
    check("busy_start", 128'(oBusy), 128'(want > 0));
    while (!oDone && cyc < 40000 && !(abortAt >= 0 && sent == abortAt)) begin
      iValid = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
      iData = dataOf(sent);
      iStart = (cyc == restartAt);
      if (iStart) iNumWords = 14'd3;
      acc = iValid && oReady;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        since = 0;
        if (sent == want) begin
          check("flush_ready", 128'(oReady), 128'(0));
          check("flush_busy", 128'(oBusy), 128'(1));
        end
      end else if (since >= 0) since++;
    end
    iStart = 0;
    if (abortAt >= 0) return;
    check("done_seen", 128'(oDone), 128'(1));
    check("accepts", 128'(sent), 128'(want));
    if (want > 0) check("done_lat", 128'(since), 128'(1));
    @(posedge clk); #1;
    check("done_pulse", 128'(oDone), 128'(0));
    check("idle_busy", 128'(oBusy), 128'(0));
    check("strobes", 128'(expK), 128'(want));
  endtask

  initial begin
    int doneSeen;
    rstn = 0; iStart = 0; iValid = 1; iNumWords = 14'd5; iData = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(oReady), 128'(0));
    check("rst_ena", 128'(o_ena), 128'(0));
    check("rst_wea", 128'(o_wea), 128'(0));
    check("rst_addr", 128'(o_addra), 128'(0));
    check("rst_dia", o_dia, 128'(0));
    check("rst_busy", 128'(oBusy), 128'(0));
    check("rst_done", 128'(oDone), 128'(0));
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 128'(oReady), 128'(0));
    check("idle_wea", 128'(o_wea), 128'(0));

    salt = 0; bub = 0;
    runLoad(20, -1, -1);
    check("n20_bank0", 128'(bankCnt[0]), 128'(2));
    check("n20_bank3", 128'(bankCnt[3]), 128'(2));
    check("n20_bank4", 128'(bankCnt[4]), 128'(1));
    check("n20_last", 128'({lastBank, lastAddr}), 128'({32'd3, 32'd1}));

    salt = 7; bub = 1;
    runLoad(8192, -1, -1);
    for (int b = 0; b < 16; b++) check("full_bank", 128'(bankCnt[b]), 128'(512));
    check("full_last_bank", 128'(lastBank), 128'(15));
    check("full_last_addr", 128'(lastAddr), 128'(511));

    runLoad(0, -1, -1);
    bub = 0;
    runLoad(9000, -1, -1);
    check("sat_last_addr", 128'(lastAddr), 128'(511));

    salt = 3; bub = 1;
    runLoad(20, -1, 4);

    bub = 0;
    runLoad(32, 5, -1);
    rstn = 0; iValid = 1; iData = dataOf(5);
    @(posedge clk); #1;
    check("abort_ena", 128'(o_ena), 128'(0));
    check("abort_wea", 128'(o_wea), 128'(0));
    check("abort_addr", 128'(o_addra), 128'(0));
    check("abort_dia", o_dia, 128'(0));
    check("abort_busy", 128'(oBusy), 128'(0));
    check("abort_ready", 128'(oReady), 128'(0));
    doneSeen = 0;
    @(posedge clk); #1;
    rstn = 1;
    repeat (6) begin
      @(posedge clk); #1;
      doneSeen += int'(oDone);
    end
    check("abort_nodone", 128'(doneSeen), 128'(0));
    check("abort_strobes", 128'(expK), 128'(5));
    runLoad(4, -1, -1);
    check("fresh_bank3", 128'(bankCnt[3]), 128'(1));
    check("fresh_last", 128'({lastBank, lastAddr}), 128'({32'd3, 32'd0}));

`ifdef LOADER_CHECKSUM_EN
    salt = 1;
    runLoad(2, -1, -1);
    check("checksum", 128'(oChecksum), 128'(8));
`endif

    monOn = 0;
    $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
    $finish;
  end
endmodule
